// File: rtl/gate_pkg.sv
// Shared definitions for the gate sweep unit.
//   mode_e        : gate function selector (6 and 7 are reserved and evaluate to 0)
//   state_e       : sweep sequencer states
//   gate_eval()   : reference gate evaluation over the low n bits of v
//   mode_reserved(): true for the two reserved mode codes
package gate_pkg;

    typedef enum logic [2:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XNOR = 3'd5,
        MODE_RSV6 = 3'd6,
        MODE_RSV7 = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Evaluate the selected gate over bits [n-1:0] of v; bits above n are ignored.
    function automatic logic gate_eval(mode_e m, logic [7:0] v, int n);
        logic a;
        logic o;
        logic x;
        a = 1'b1;
        o = 1'b0;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                a = a & v[i];
                o = o | v[i];
                x = x ^ v[i];
            end
        end
        case (m)
            MODE_AND:  return a;
            MODE_OR:   return o;
            MODE_XOR:  return x;
            MODE_NAND: return ~a;
            MODE_NOR:  return ~o;
            MODE_XNOR: return ~x;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic mode_reserved(logic [2:0] m);
        return m[2] & m[1];
    endfunction

endpackage

// File: rtl/gate_reduce.sv
// Purely combinational N-input gate.
//   mode : gate selector (mode_e encoding); reserved codes give 0
//   vec  : gate inputs
//   y    : gate result
module gate_reduce
    import gate_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [2:0]      mode,
    input  logic [N_IN-1:0] vec,
    output logic            y
);

    always_comb begin
        // NOTE: assigning a default before the case guarantees every path drives y, so no latch is inferred.
        y = 1'b0;
        case (mode_e'(mode))
            MODE_AND:  y = &vec;
            MODE_OR:   y = |vec;
            MODE_XOR:  y = ^vec;
            MODE_NAND: y = ~&vec;
            MODE_NOR:  y = ~|vec;
            MODE_XNOR: y = ~^vec;
            MODE_RSV6: y = 1'b0;
            MODE_RSV7: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_unit.sv
// N-input logic gate with registered output and an exhaustive sweep sequencer.
// In IDLE the gate can be evaluated directly on ext_in; a start launches a
// sweep that applies every input vector 0 .. 2^N_IN-1 for STEP_CYCLES clocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a sweep (sampled in IDLE, wins over ext_en)
//   mode       : gate selector, latched at start for the whole sweep
//   ext_en     : direct mode strobe, ext_in : direct mode inputs
//   vec_out    : vector applied by the sweep (0 outside a sweep)
//   y_out      : registered gate result, valid_out : y_out is new this cycle
//   busy       : sweep in progress or completing, done : completion pulse
//   vec_count  : results produced in the current/last sweep
//   mode_err   : sticky flag, a reserved mode was used
module gate_sweep_unit
    import gate_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int STEP_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      mode,
    input  logic            ext_en,
    input  logic [N_IN-1:0] ext_in,
    output logic [N_IN-1:0] vec_out,
    output logic            y_out,
    output logic            valid_out,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   vec_count,
    output logic            mode_err
);

    localparam int              HW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(STEP_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    state_e          state_q;
    state_e          state_d;
    mode_e           mode_q;
    logic [N_IN-1:0] vec_q;
    logic [HW-1:0]   hold_q;
    logic            primed_q;
    logic            y_q;
    logic            valid_q;
    logic [N_IN:0]   count_q;
    logic            err_q;

    logic [2:0]      eval_mode;
    logic [N_IN-1:0] eval_in;
    logic            eval_y;
    logic            last_hold;
    logic            first_show;

    // The single gate is shared: live inputs in IDLE, the sweep vector otherwise.
    assign eval_mode = (state_q == ST_IDLE) ? mode   : mode_q;
    assign eval_in   = (state_q == ST_IDLE) ? ext_in : vec_q;

    gate_reduce #(.N_IN(N_IN)) u_reduce (
        .mode (eval_mode),
        .vec  (eval_in),
        .y    (eval_y)
    );

    // The first SWEEP cycle only primes the sequencer (vec_out already 0), so
    // vector 0 is first shown one edge after start is sampled.
    assign last_hold  = primed_q && (hold_q == HOLD_LAST);
    assign first_show = (state_q == ST_SWEEP) && primed_q && (hold_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SWEEP;
            ST_SWEEP: if (last_hold && (vec_q == VEC_LAST)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_AND;
            vec_q    <= '0;
            hold_q   <= '0;
            primed_q <= 1'b0;
            y_q      <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q   <= mode_e'(mode);
                        vec_q    <= '0;
                        hold_q   <= '0;
                        primed_q <= 1'b0;
                        count_q  <= '0;
                        if (mode_reserved(mode)) err_q <= 1'b1;
                    end else if (ext_en) begin
                        y_q     <= eval_y;
                        valid_q <= 1'b1;
                        if (mode_reserved(mode)) err_q <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (!primed_q) begin
                        primed_q <= 1'b1;
                    end else begin
                        if (first_show) begin
                            y_q     <= eval_y;
                            valid_q <= 1'b1;
                            count_q <= count_q + (N_IN+1)'(1);
                        end
                        if (last_hold) begin
                            hold_q <= '0;
                            // The final vector returns to 0 rather than wrapping.
                            vec_q  <= (vec_q == VEC_LAST) ? '0 : vec_q + N_IN'(1);
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign vec_out   = vec_q;
    assign y_out     = y_q;
    assign valid_out = valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign vec_count = count_q;
    assign mode_err  = err_q;

endmodule

// File: tb/tb_gate_sweep_unit.sv
module tb_gate_sweep_unit;
    import gate_pkg::*;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic         ext_en = 1'b0;
    logic [N-1:0] ext_in = '0;

    logic [N-1:0] vec_a, vec_b;
    logic         y_a, y_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [N:0]   cnt_a, cnt_b;
    logic         err_a, err_b;

    always #5 clk = ~clk;

    gate_sweep_unit #(.N_IN(N), .STEP_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .ext_en(ext_en), .ext_in(ext_in),
        .vec_out(vec_a), .y_out(y_a), .valid_out(valid_a), .busy(busy_a), .done(done_a),
        .vec_count(cnt_a), .mode_err(err_a)
    );

    gate_sweep_unit #(.N_IN(N), .STEP_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .ext_en(ext_en), .ext_in(ext_in),
        .vec_out(vec_b), .y_out(y_b), .valid_out(valid_b), .busy(busy_b), .done(done_b),
        .vec_count(cnt_b), .mode_err(err_b)
    );

    typedef struct {
        logic y;
        int   cnt;   // expected vec_count at the valid cycle, -1 = direct mode (not checked)
    } exp_t;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] bits;   // bit v = expected result for vector v
        string      name;
    } sweep_vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t make_exp(logic y, int cnt);
        exp_t e;
        e.y   = y;
        e.cnt = cnt;
        return e;
    endfunction

    // Scoreboard: every valid_out pops one expectation pushed when stimulus was driven.
    exp_t ea, eb;
    always @(negedge clk) begin
        if (rst_n && valid_a) begin
            if (q_a.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
            else begin
                ea = q_a.pop_front();
                check("a_y_out", {31'd0, y_a}, {31'd0, ea.y});
                if (ea.cnt >= 0) check("a_vec_count", {28'd0, cnt_a}, ea.cnt);
            end
        end
        if (rst_n && valid_b) begin
            if (q_b.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
            else begin
                eb = q_b.pop_front();
                check("b_y_out", {31'd0, y_b}, {31'd0, eb.y});
                if (eb.cnt >= 0) check("b_vec_count", {28'd0, cnt_b}, eb.cnt);
            end
        end
    end

    // Called at the negedge following the start edge (cycle 0); returns the
    // number of cycles after the start edge at which done was seen.
    task automatic wait_done_a(output int cyc);
        cyc = 0;
        while (!done_a && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_sweep_a(input logic [2:0] m, input logic [7:0] bits, input string nm,
                               input bit with_ext);
        int cyc;
        @(negedge clk);
        mode    = m;
        start_a = 1'b1;
        for (int v = 0; v < 8; v++) q_a.push_back(make_exp(bits[v], v + 1));
        if (with_ext) begin
            ext_en = 1'b1;
            ext_in = 3'b111;
            q_b.push_back(make_exp(gate_eval(mode_e'(m), 8'h07, N), -1));
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        ext_en  = 1'b0;
        @(negedge clk);
        check({nm, "_busy"}, {31'd0, busy_a}, 32'd1);
        if (with_ext) check("start_beats_ext_valid", {31'd0, valid_a}, 32'd0);
        wait_done_a(cyc);
        check({nm, "_done_cycle"}, cyc, 32'd9);
        check({nm, "_done_count"}, {28'd0, cnt_a}, 32'd8);
        check({nm, "_done_vec"}, {29'd0, vec_a}, 32'd0);
        @(negedge clk);
        check({nm, "_after_done"}, {30'd0, busy_a, done_a}, 32'd0);
        check({nm, "_all_results"}, q_a.size(), 32'd0);
    endtask

    initial begin
        sweep_vec_t tbl[6];
        int         cyc;
        int         hist[8];
        int         vpos[16];
        int         nv;
        int         seen;
        logic       last_y;

        tbl[0] = '{mode: 3'd0, bits: 8'h80, name: "and"};
        tbl[1] = '{mode: 3'd1, bits: 8'hFE, name: "or"};
        tbl[2] = '{mode: 3'd2, bits: 8'h96, name: "xor"};
        tbl[3] = '{mode: 3'd3, bits: 8'h7F, name: "nand"};
        tbl[4] = '{mode: 3'd4, bits: 8'h01, name: "nor"};
        tbl[5] = '{mode: 3'd5, bits: 8'h69, name: "xnor"};

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("reset_a_outputs", {20'd0, vec_a, y_a, valid_a, busy_a, done_a, cnt_a, err_a}, 32'd0);
        check("reset_b_outputs", {20'd0, vec_b, y_b, valid_b, busy_b, done_b, cnt_b, err_b}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sweeps, STEP_CYCLES=1
        for (int i = 0; i < 6; i++) run_sweep_a(tbl[i].mode, tbl[i].bits, tbl[i].name, 1'b0);

        // start and ext_en together: the sweep wins, only dut_b does a direct evaluation
        run_sweep_a(3'd0, 8'h80, "start_ext", 1'b1);

        // STEP_CYCLES=3 sweep on dut_b
        for (int v = 0; v < 8; v++) hist[v] = 0;
        nv = 0;
        @(negedge clk);
        mode    = 3'd2;
        start_b = 1'b1;
        for (int v = 0; v < 8; v++) q_b.push_back(make_exp(tbl[2].bits[v], v + 1));
        @(posedge clk);
        #1 start_b = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (!done_b && cyc < 80) begin
            if (valid_b && nv < 16) begin
                vpos[nv] = cyc;
                nv++;
            end
            hist[vec_b]++;
            @(negedge clk);
            cyc++;
        end
        check("step3_done_cycle", cyc, 32'd25);
        check("step3_done_count", {28'd0, cnt_b}, 32'd8);
        check("step3_valid_pulses", nv, 32'd8);
        for (int v = 1; v < 8; v++) check("step3_vec_hold", hist[v], 32'd3);
        for (int i = 0; i + 1 < nv && i < 15; i++) check("step3_valid_spacing", vpos[i+1] - vpos[i], 32'd3);
        @(negedge clk);
        check("step3_all_results", q_b.size(), 32'd0);

        // Direct mode: NOR on 000 then 100, then random modes/vectors
        @(negedge clk);
        mode   = 3'd4;
        ext_en = 1'b1;
        ext_in = 3'b000;
        q_a.push_back(make_exp(1'b1, -1));
        q_b.push_back(make_exp(1'b1, -1));
        @(negedge clk);
        ext_in = 3'b100;
        q_a.push_back(make_exp(1'b0, -1));
        q_b.push_back(make_exp(1'b0, -1));
        last_y = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mode   = 3'($urandom_range(0, 5));
            ext_in = N'($urandom);
            last_y = gate_eval(mode_e'(mode), {5'd0, ext_in}, N);
            q_a.push_back(make_exp(last_y, -1));
            q_b.push_back(make_exp(last_y, -1));
        end
        @(negedge clk);
        ext_en = 1'b0;
        @(negedge clk);
        check("direct_valid_drops", {31'd0, valid_a}, 32'd0);
        check("direct_y_holds", {31'd0, y_a}, {31'd0, last_y});
        check("direct_all_results", q_a.size() + q_b.size(), 32'd0);
        check("direct_no_mode_err", {30'd0, err_a, err_b}, 32'd0);

        // start held high: a second sweep begins the cycle after DONE
        @(negedge clk);
        mode    = 3'd1;
        start_a = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int v = 0; v < 8; v++) q_a.push_back(make_exp(tbl[1].bits[v], v + 1));
        @(negedge clk);
        wait_done_a(cyc);
        check("held_first_done", cyc, 32'd9);
        @(negedge clk);
        cyc++;
        check("held_gap_no_done", {31'd0, done_a}, 32'd0);
        while (!done_a && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("held_second_done", cyc, 32'd20);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        check("held_idle_after", {31'd0, busy_a}, 32'd0);
        check("held_all_results", q_a.size(), 32'd0);

        // Reset in the middle of a sweep at vec_out=5
        @(negedge clk);
        mode    = 3'd1;
        start_a = 1'b1;
        for (int v = 0; v < 8; v++) q_a.push_back(make_exp(tbl[1].bits[v], v + 1));
        @(posedge clk);
        #1 start_a = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (vec_a != 3'd5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("midreset_reached_vec5", {31'd0, vec_a == 3'd5}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {20'd0, vec_a, y_a, valid_a, busy_a, done_a, cnt_a, err_a}, 32'd0);
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_a || valid_a) seen++;
        end
        check("midreset_no_done", seen, 32'd0);
        run_sweep_a(3'd1, 8'hFE, "rerun", 1'b0);

        // Reserved mode: results 0, mode_err sticky
        check("mode_err_clear", {31'd0, err_a}, 32'd0);
        run_sweep_a(3'd6, 8'h00, "rsv6", 1'b0);
        check("mode_err_set", {31'd0, err_a}, 32'd1);
        repeat (4) @(negedge clk);
        check("mode_err_sticky", {31'd0, err_a}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
